// File: rtl/reg_uart.sv
// reg_uart: register-mapped UART with TX FIFO, RX holding byte, baud divider and sticky error flags.
// Define UART_IRQ_EN to add the irq output and the IRQ_EN register at offset 0x04.
module reg_uart #(
    parameter int          TX_FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET     = 16'd433
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_address,
    input  logic [7:0] bus_data_tx,
    output logic [7:0] bus_data_rx,
    input  logic       bus_read,
    input  logic       bus_write,
    output logic       bus_wait,
    output logic       uart_tx,
    input  logic       uart_rx
`ifdef UART_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int AW = $clog2(TX_FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ---------------- bus handshake and decode ----------------
    logic ack_q;
    logic strobe, access, wr_acc, rd_acc;
    logic wr_data, wr_stat, wr_dlo, wr_dhi, rd_data;

    assign strobe   = bus_read | bus_write;
    assign access   = strobe & ~ack_q;
    assign wr_acc   = access & bus_write;
    assign rd_acc   = access & bus_read & ~bus_write;
    assign bus_wait = access;

    assign wr_data = wr_acc && (bus_address == 8'h00);
    assign wr_stat = wr_acc && (bus_address == 8'h01);
    assign wr_dlo  = wr_acc && (bus_address == 8'h02);
    assign wr_dhi  = wr_acc && (bus_address == 8'h03);
    assign rd_data = rd_acc && (bus_address == 8'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= strobe;
        end
    end

    // ---------------- baud divider ----------------
    logic [15:0] div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= DIV_RESET;
        end else begin
            if (wr_dlo) div[7:0]  <= bus_data_tx;
            if (wr_dhi) div[15:8] <= bus_data_tx;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        tx_full, tx_empty, push, tx_pop, tx_ovf_set;

    assign tx_empty   = (wr_ptr == rd_ptr);
    assign tx_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = wr_data & ~tx_full;
    assign tx_ovf_set = wr_data & tx_full;

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus_data_tx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- TX state machine ----------------
    logic [1:0]  tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_tick, tx_busy;

    assign tx_tick = (tx_cnt == '0);
    assign tx_busy = (tx_state != S_IDLE);
    // A new frame can be started from IDLE or straight out of the last stop-bit clock.
    assign tx_pop  = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_tick));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
                        tx_cnt   <= div;
                        uart_tx  <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_tick) begin
                        tx_cnt   <= div;
                        tx_bit   <= '0;
                        uart_tx  <= tx_shift[0];
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_tick) begin
                        tx_cnt <= div;
                        if (tx_bit == 3'd7) begin
                            uart_tx  <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            uart_tx  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (tx_tick) begin
                        if (tx_pop) begin
                            tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
                            tx_cnt   <= div;
                            uart_tx  <= 1'b0;
                            tx_state <= S_START;
                        end else begin
                            tx_state <= S_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX synchronizer and state machine ----------------
    logic        rx_s1, rx_s2, rx_prev;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_fall, rx_tick, rx_stop_sample, rx_done, rx_ferr_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall        = rx_prev & ~rx_s2;
    assign rx_tick        = (rx_cnt == '0);
    assign rx_stop_sample = (rx_state == S_STOP) & rx_tick;
    assign rx_done        = rx_stop_sample & rx_s2;
    assign rx_ferr_set    = rx_stop_sample & ~rx_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt   <= {1'b0, div[15:1]};
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_tick) begin
                        if (rx_s2) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_cnt   <= div;
                            rx_bit   <= '0;
                            rx_state <= S_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_tick) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= div;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_STOP: begin
                    if (rx_tick) rx_state <= S_IDLE;
                    else         rx_cnt   <= rx_cnt - 1'b1;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX holding register and sticky flags ----------------
    logic [7:0] rx_hold;
    logic       rx_valid, rx_ovr, tx_ovf, frame_err, rx_ovr_set;

    // A DATA read on the same edge as a new byte frees the holder, so the byte is kept.
    assign rx_ovr_set = rx_done & rx_valid & ~rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_hold  <= '0;
            rx_valid <= 1'b0;
        end else if (rx_done & (~rx_valid | rd_data)) begin
            rx_hold  <= rx_shift;
            rx_valid <= 1'b1;
        end else if (rd_data) begin
            rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovr    <= 1'b0;
            tx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_ovr    <= rx_ovr_set  | (rx_ovr    & ~(wr_stat & bus_data_tx[4]));
            tx_ovf    <= tx_ovf_set  | (tx_ovf    & ~(wr_stat & bus_data_tx[5]));
            frame_err <= rx_ferr_set | (frame_err & ~(wr_stat & bus_data_tx[6]));
        end
    end

    // ---------------- optional interrupt ----------------
`ifdef UART_IRQ_EN
    logic [2:0] irq_en;
    logic       wr_irq;

    assign wr_irq = wr_acc && (bus_address == 8'h04);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr_irq) irq_en <= bus_data_tx[2:0];
            irq <= |(irq_en & {rx_ovr | tx_ovf | frame_err, tx_empty, rx_valid});
        end
    end
`endif

    // ---------------- read path ----------------
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (bus_address)
            8'h00: rd_mux = rx_hold;
            8'h01: rd_mux = {1'b0, frame_err, tx_ovf, rx_ovr, rx_valid, tx_busy, tx_empty, tx_full};
            8'h02: rd_mux = div[7:0];
            8'h03: rd_mux = div[15:8];
`ifdef UART_IRQ_EN
            8'h04: rd_mux = {5'b0, irq_en};
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_data_rx <= '0;
        end else if (rd_acc) begin
            bus_data_rx <= rd_mux;
        end
    end

endmodule

// File: tb/tb_reg_uart.sv
// tb_reg_uart: randomized self-checking bench for reg_uart with a frame-level serial reference model.
`timescale 1ns/1ps
module tb_reg_uart;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_address;
    logic [7:0] bus_data_tx;
    logic [7:0] bus_data_rx;
    logic       bus_read;
    logic       bus_write;
    logic       bus_wait;
    logic       uart_tx;
    logic       uart_rx;
`ifdef UART_IRQ_EN
    logic       irq;
`endif

    reg_uart #(
        .TX_FIFO_DEPTH(4),
        .DIV_RESET    (16'd433)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_address(bus_address),
        .bus_data_tx(bus_data_tx),
        .bus_data_rx(bus_data_rx),
        .bus_read   (bus_read),
        .bus_write  (bus_write),
        .bus_wait   (bus_wait),
        .uart_tx    (uart_tx),
        .uart_rx    (uart_rx)
`ifdef UART_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned m_div    = 433;
    bit          mon_en   = 1'b0;
    logic [7:0]  tx_got[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] st(input bit full, input bit empty, input bit busy, input bit rxv,
                                      input bit ovr, input bit ovf, input bit ferr);
        return {1'b0, ferr, ovf, ovr, rxv, busy, empty, full};
    endfunction

    task automatic bus_access(input logic [7:0] a, input logic [7:0] d, input bit is_wr,
                              output logic [7:0] rdat);
        int unsigned wc;
        wc = 0;
        @(negedge clk);
        bus_address = a;
        bus_data_tx = d;
        bus_write   = is_wr;
        bus_read    = !is_wr;
        #1;
        while (bus_wait === 1'b1 && wc < 8) begin
            @(posedge clk);
            #1;
            wc++;
        end
        check("bus_wait_cycles", wc, 1);
        rdat = bus_data_rx;
        @(negedge clk);
        bus_read  = 1'b0;
        bus_write = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        bus_access(a, d, 1'b1, dummy);
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        bus_access(a, 8'h00, 1'b0, d);
    endtask

    // Serial line stimulus: start bit, 8 data bits LSB first, stop bit, then idle.
    task automatic send_rx(input logic [7:0] b, input logic stop_b, input int unsigned bitc);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (bitc) @(negedge clk);
        end
        uart_rx = stop_b;
        repeat (bitc) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx(input int unsigned n, input int unsigned budget);
        int unsigned c;
        c = 0;
        while (tx_got.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("tx_frame_timeout", (tx_got.size() >= n), 1);
    endtask

    // Reference receiver for uart_tx: samples mid-bit using the current model divider.
    initial begin
        int unsigned bitc;
        logic [7:0]  b;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                bitc = m_div + 1;
                repeat (bitc / 2) @(negedge clk);
                check("tx_start_bit", uart_tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (bitc) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (bitc) @(negedge clk);
                check("tx_stop_bit", uart_tx, 1);
                tx_got.push_back(b);
            end
        end
    end

    initial begin
        logic [7:0]  got, tb_b, rb, b1, b2;
        logic [7:0]  burst [6];
        logic [43:0] wave, wave_exp;
        bit          seen;

        rst_n       = 1'b0;
        uart_rx     = 1'b1;
        bus_address = '0;
        bus_data_tx = '0;
        bus_read    = 1'b0;
        bus_write   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_bus_wait", bus_wait, 0);
        check("reset_bus_data_rx", bus_data_rx, 8'h00);
        rst_n  = 1'b1;
        m_div  = 433;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        rd(8'h01, got); check("reset_status", got, st(0, 1, 0, 0, 0, 0, 0));
        rd(8'h02, got); check("reset_div_lo", got, m_div % 256);
        rd(8'h03, got); check("reset_div_hi", got, m_div / 256);
`ifdef UART_IRQ_EN
        check("reset_irq", irq, 0);
`endif

        // Single frame, cycle-exact waveform at DIV=3.
        wr(8'h02, 8'd3); wr(8'h03, 8'd0); m_div = 3;
        tx_got.delete();
        tb_b = 8'hA5;
        wr(8'h00, tb_b);
        for (int i = 0; i < 44; i++) begin
            if (i < 4)       wave_exp[i] = 1'b0;
            else if (i < 36) wave_exp[i] = tb_b[(i / 4) - 1];
            else             wave_exp[i] = 1'b1;
        end
        fork
            begin
                seen = 1'b0;
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(negedge clk);
                    if (uart_tx === 1'b0) seen = 1'b1;
                end
                check("a5_start_seen", seen, 1);
                wave[0] = uart_tx;
                for (int i = 1; i < 44; i++) begin
                    @(negedge clk);
                    wave[i] = uart_tx;
                end
                check("a5_waveform", wave, wave_exp);
            end
            begin
                logic [7:0] s;
                repeat (12) @(negedge clk);
                rd(8'h01, s);
                check("a5_busy", s[2], 1);
            end
        join
        wait_tx(1, 100);
        if (tx_got.size() > 0) check("a5_decoded", tx_got[0], tb_b);
        repeat (8) @(negedge clk);

        // FIFO overflow: 1 in flight + 4 queued, sixth byte dropped.
        tx_got.delete();
        for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) wr(8'h00, burst[i]);
        rd(8'h01, got); check("ovf_status", got, st(1, 0, 1, 0, 0, 1, 0));
        wait_tx(5, 600);
        repeat (60) @(negedge clk);
        check("ovf_frame_count", tx_got.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < tx_got.size()) check("ovf_frame_byte", tx_got[i], burst[i]);
        rd(8'h01, got); check("ovf_status_idle", got, st(0, 1, 0, 0, 0, 1, 0));
        wr(8'h01, 8'h20);
        rd(8'h01, got); check("ovf_cleared", got, st(0, 1, 0, 0, 0, 0, 0));

        // Randomized divider, TX byte and RX byte.
        for (int r = 0; r < 4; r++) begin
            m_div = $urandom_range(10, 3);
            wr(8'h02, 8'(m_div)); wr(8'h03, 8'h00);
            rd(8'h02, got); check("rand_div_lo", got, m_div % 256);
            tx_got.delete();
            tb_b = 8'($urandom);
            wr(8'h00, tb_b);
            wait_tx(1, 20 * (m_div + 1));
            if (tx_got.size() > 0) check("rand_tx_byte", tx_got[0], tb_b);
            repeat (m_div + 1) @(negedge clk);
            rb = 8'($urandom);
            send_rx(rb, 1'b1, m_div + 1);
            rd(8'h00, got); check("rand_rx_byte", got, rb);
            rd(8'h01, got); check("rand_status", got, st(0, 1, 0, 0, 0, 0, 0));
        end

        // RX holding register behaviour at DIV=3.
        wr(8'h02, 8'd3); m_div = 3;
        send_rx(8'h3C, 1'b1, 4);
        rd(8'h01, got); check("rx_valid_set", got, st(0, 1, 0, 1, 0, 0, 0));
        rd(8'h00, got); check("rx_3c", got, 8'h3C);
        rd(8'h01, got); check("rx_valid_clr", got, st(0, 1, 0, 0, 0, 0, 0));
        rd(8'h00, got); check("rx_last_byte", got, 8'h3C);

        b1 = 8'($urandom); b2 = 8'($urandom);
        send_rx(b1, 1'b1, 4);
        send_rx(b2, 1'b1, 4);
        rd(8'h00, got); check("ovr_first_kept", got, b1);
        rd(8'h01, got); check("ovr_status", got, st(0, 1, 0, 0, 1, 0, 0));
        wr(8'h01, 8'h10);
        rd(8'h01, got); check("ovr_cleared", got, st(0, 1, 0, 0, 0, 0, 0));

        send_rx(8'($urandom), 1'b0, 4);
        rd(8'h01, got); check("frame_err", got, st(0, 1, 0, 0, 0, 0, 1));
        wr(8'h01, 8'h40);
        rd(8'h01, got); check("frame_err_cleared", got, st(0, 1, 0, 0, 0, 0, 0));

        @(negedge clk); uart_rx = 1'b0;
        @(negedge clk); uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        rd(8'h01, got); check("glitch_no_flags", got, st(0, 1, 0, 0, 0, 0, 0));
        rb = 8'($urandom);
        send_rx(rb, 1'b1, 4);
        rd(8'h00, got); check("after_glitch_rx", got, rb);

`ifdef UART_IRQ_EN
        wr(8'h04, 8'h02);
        repeat (2) @(negedge clk);
        check("irq_tx_empty", irq, 1);
        rd(8'h04, got); check("irq_en_read", got, 8'h02);
        wr(8'h04, 8'h04);
        repeat (2) @(negedge clk);
        check("irq_no_error", irq, 0);
        wr(8'h04, 8'h00);
`else
        wr(8'h04, 8'hFF);
        rd(8'h04, got); check("unmapped_04", got, 8'h00);
`endif
        rd(8'h07, got); check("unmapped_07", got, 8'h00);

        // Reset during a frame: line returns high at once and queued data is lost.
        mon_en = 1'b0;
        wr(8'h00, 8'h00);
        wr(8'h00, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (uart_tx === 1'b0) seen = 1'b1;
        end
        check("midreset_start_seen", seen, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_tx_high", uart_tx, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_div = 433;
        rd(8'h01, got); check("midreset_status", got, st(0, 1, 0, 0, 0, 0, 0));
        rd(8'h02, got); check("midreset_div_lo", got, m_div % 256);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) seen = 1'b1;
        end
        check("midreset_fifo_lost", seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
